// File: rtl/systolic_top_uart_4parallel_pkg.sv
// Shared widths and request record for the shared-multiplier arbiter.
// Handshake rule on every channel: a beat transfers on a rising edge where valid & ready.
package systolic_top_uart_4parallel_pkg;
  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;
  localparam int DIN_W  = 28;
  localparam int DOUT_W = 52;

  typedef struct packed {
    logic signed [DIN_W-1:0] a;
    logic signed [DIN_W-1:0] b;
    logic [ID_W-1:0]         id;
  } mul_req_t;
endpackage

// File: rtl/systolic_top_uart_4parallel_mul_arb_if.sv
// Lane request channels, tagged product channel, status and pointer debug view.
interface systolic_top_uart_4parallel_mul_arb_if;
  import systolic_top_uart_4parallel_pkg::*;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*DIN_W-1:0] req_a;
  logic [N_REQ*DIN_W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DOUT_W-1:0]      rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   busy;
  logic [ID_W-1:0]        ptr;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy, ptr
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy, ptr
  );
endinterface

// File: rtl/systolic_top_uart_4parallel_mul_28s_28s_52_1_1.sv
// Combinational signed multiplier keeping the low dout_WIDTH bits (wraps on overflow).
module systolic_top_uart_4parallel_mul_28s_28s_52_1_1 #(
  parameter int din0_WIDTH = 28,
  parameter int din1_WIDTH = 28,
  parameter int dout_WIDTH = 52
) (
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic        [dout_WIDTH-1:0] dout
);
  logic signed [dout_WIDTH-1:0] a_ext;
  logic signed [dout_WIDTH-1:0] b_ext;

  // Low bits of the product depend only on the low bits of sign-extended operands.
  assign a_ext = dout_WIDTH'(din0);
  assign b_ext = dout_WIDTH'(din1);
  assign dout  = a_ext * b_ext;
endmodule

// File: rtl/systolic_top_uart_4parallel_mul_arb.sv
// Round-robin arbiter feeding a two-stage pipeline around one shared signed multiplier.
module systolic_top_uart_4parallel_mul_arb
  import systolic_top_uart_4parallel_pkg::*;
(
  input logic ap_clk,
  input logic ap_rst,
  systolic_top_uart_4parallel_mul_arb_if.slave bus
);

  // Rotate by ptr, take the lowest set bit, rotate back. Returns {found, lane}.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                            input logic [ID_W-1:0]  start);
    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  idx;
    rot = N_REQ'({valid, valid} >> start);
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = ID_W'(i);
    end
    return {|valid, idx + start};
  endfunction

  logic [ID_W-1:0]   ptr_q;
  logic [ID_W:0]     pick;
  logic              found;
  logic [ID_W-1:0]   gnt;
  logic              adv0;
  logic              adv2;
  logic              xfer;
  mul_req_t          s1_d;
  mul_req_t          s1_q;
  logic              v1_q;
  logic [DOUT_W-1:0] prod;
  logic              rv_q;
  logic [DOUT_W-1:0] data_q;
  logic [ID_W-1:0]   id_q;

  always_comb begin
    pick    = rr_pick(bus.req_valid, ptr_q);
    found   = pick[ID_W];
    gnt     = pick[ID_W-1:0];
    adv2    = !rv_q || bus.rsp_ready;
    adv0    = !v1_q || adv2;
    xfer    = found && adv0 && !ap_rst;
    s1_d.a  = bus.req_a[gnt*DIN_W +: DIN_W];
    s1_d.b  = bus.req_b[gnt*DIN_W +: DIN_W];
    s1_d.id = gnt;
    bus.req_ready = '0;
    if (xfer) bus.req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr_q <= '0;
      v1_q  <= 1'b0;
      s1_q  <= '0;
    end else begin
      if (xfer) ptr_q <= gnt + ID_W'(1);
      if (adv0) begin
        v1_q <= found;
        if (found) s1_q <= s1_d;
      end
    end
  end

  systolic_top_uart_4parallel_mul_28s_28s_52_1_1 #(
    .din0_WIDTH(DIN_W),
    .din1_WIDTH(DIN_W),
    .dout_WIDTH(DOUT_W)
  ) u_mul (
    .din0(s1_q.a),
    .din1(s1_q.b),
    .dout(prod)
  );

  // Data/id only load with a real beat, so a bubble leaves the last product in place.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rv_q   <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
    end else if (adv2) begin
      rv_q <= v1_q;
      if (v1_q) begin
        data_q <= prod;
        id_q   <= s1_q.id;
      end
    end
  end

  assign bus.rsp_valid = rv_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;
  assign bus.busy      = v1_q | rv_q;
  assign bus.ptr       = ptr_q;

endmodule

// File: tb/tb_systolic_top_uart_4parallel_mul_arb.sv
// Directed bench for the shared-multiplier arbiter: reset, latency, round robin, extremes, stall, reset mid-flight.
module tb_systolic_top_uart_4parallel_mul_arb;
  import systolic_top_uart_4parallel_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst;
  int   errors = 0;
  int   checks = 0;
  logic [ID_W+DOUT_W-1:0] exp_q[$];

  always #5 ap_clk = ~ap_clk;

  systolic_top_uart_4parallel_mul_arb_if bus();

  systolic_top_uart_4parallel_mul_arb dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DOUT_W-1:0] prod(input longint a, input longint b);
    longint p;
    p = a * b;
    return p[DOUT_W-1:0];
  endfunction

  task automatic set_lane(input int i, input longint a, input longint b);
    bus.req_a[i*DIN_W +: DIN_W] = a[DIN_W-1:0];
    bus.req_b[i*DIN_W +: DIN_W] = b[DIN_W-1:0];
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic observe(input string tag);
    logic [ID_W+DOUT_W-1:0] e;
    if (bus.rsp_valid && bus.rsp_ready) begin
      check({tag, "_expected"}, 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(tag, {bus.rsp_id, bus.rsp_data}, 64'(e));
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
      #1;
      observe(tag);
      tick();
    end
    check({tag, "_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset with every lane requesting ----
    ap_rst        = 1'b1;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    #1;
    check("rst_req_ready", bus.req_ready, 64'(0));
    check("rst_rsp_valid", bus.rsp_valid, 64'(0));
    check("rst_busy",      bus.busy,      64'(0));
    check("rst_ptr",       bus.ptr,       64'(0));
    check("rst_rsp_data",  bus.rsp_data,  64'(0));
    ap_rst = 1'b0;
    #1;
    check("first_grant", bus.req_ready, 64'(4'b0001));
    bus.req_valid = '0;
    tick();

    // ---- single lane, latency ----
    set_lane(2, -3, 5);
    bus.req_valid = 4'b0100;
    #1;
    check("single_grant", bus.req_ready, 64'(4'b0100));
    tick();
    bus.req_valid = '0;
    #1;
    check("single_t1_valid", bus.rsp_valid, 64'(0));
    check("single_t1_busy",  bus.busy,      64'(1));
    check("single_ptr",      bus.ptr,       64'(3));
    tick();
    #1;
    check("single_t2_valid", bus.rsp_valid, 64'(1));
    check("single_data",     bus.rsp_data,  64'(prod(-3, 5)));
    check("single_id",       bus.rsp_id,    64'(2));
    tick();
    #1;
    check("single_idle", bus.busy, 64'(0));

    // ---- round robin at full rate ----
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_lane(i, 1000 * (i + 1), -(7 + i));
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr_grant%0d", k), bus.req_ready, 64'(1 << (k % 4)));
      if (k >= 2) check($sformatf("rr_valid%0d", k), bus.rsp_valid, 64'(1));
      observe("rr_rsp");
      exp_q.push_back({ID_W'(k % 4), prod(1000 * (k % 4 + 1), -(7 + k % 4))});
      tick();
    end
    bus.req_valid = '0;
    drain("rr_drain");

    // ---- operand extremes ----
    set_lane(0, -(64'sd1 <<< 27), -(64'sd1 <<< 27));
    bus.req_valid = 4'b0001;
    #1;
    check("ext0_grant", bus.req_ready, 64'(4'b0001));
    tick();
    bus.req_valid = '0;
    tick();
    #1;
    check("ext0_valid", bus.rsp_valid, 64'(1));
    check("ext0_data",  bus.rsp_data,  64'(0));
    check("ext0_id",    bus.rsp_id,    64'(0));
    set_lane(1, (64'sd1 <<< 27) - 1, -1);
    bus.req_valid = 4'b0010;
    #1;
    check("ext1_grant", bus.req_ready, 64'(4'b0010));
    tick();
    bus.req_valid = '0;
    tick();
    #1;
    check("ext1_data", bus.rsp_data, 64'(prod((64'sd1 <<< 27) - 1, -1)));
    check("ext1_id",   bus.rsp_id,   64'(1));
    tick();

    // ---- backpressure on lanes 1 and 3 ----
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    set_lane(1, 11, -3);
    set_lane(3, 31, -3);
    bus.req_valid = 4'b1010;
    #1;
    check("bp_grant0", bus.req_ready, 64'(4'b0010));
    exp_q.push_back({ID_W'(1), prod(11, -3)});
    tick();
    set_lane(1, 12, -3);
    bus.rsp_ready = 1'b0;
    #1;
    check("bp_grant1", bus.req_ready, 64'(4'b1000));
    exp_q.push_back({ID_W'(3), prod(31, -3)});
    tick();
    set_lane(3, 32, -3);
    for (int s = 0; s < 5; s++) begin
      #1;
      check($sformatf("bp_hold_valid%0d", s), bus.rsp_valid, 64'(1));
      check($sformatf("bp_hold_id%0d", s),    bus.rsp_id,    64'(1));
      check($sformatf("bp_hold_data%0d", s),  bus.rsp_data,  64'(prod(11, -3)));
      check($sformatf("bp_hold_ready%0d", s), bus.req_ready, 64'(0));
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_resume_grant", bus.req_ready, 64'(4'b0010));
    observe("bp_rsp");
    exp_q.push_back({ID_W'(1), prod(12, -3)});
    tick();
    bus.req_valid = 4'b1000;
    #1;
    check("bp_grant3", bus.req_ready, 64'(4'b1000));
    observe("bp_rsp");
    exp_q.push_back({ID_W'(3), prod(32, -3)});
    tick();
    bus.req_valid = '0;
    drain("bp_drain");

    // ---- reset with both stages full ----
    bus.rsp_ready = 1'b0;
    set_lane(0, 5, 6);
    bus.req_valid = 4'b0001;
    #1;
    check("mf_grant0", bus.req_ready, 64'(4'b0001));
    tick();
    #1;
    check("mf_grant1", bus.req_ready, 64'(4'b0001));
    tick();
    #1;
    check("mf_full_valid", bus.rsp_valid, 64'(1));
    check("mf_full_ready", bus.req_ready, 64'(0));
    check("mf_full_ptr",   bus.ptr,       64'(1));
    ap_rst = 1'b1;
    tick();
    #1;
    check("mf_rst_valid", bus.rsp_valid, 64'(0));
    check("mf_rst_busy",  bus.busy,      64'(0));
    check("mf_rst_ptr",   bus.ptr,       64'(0));
    check("mf_rst_ready", bus.req_ready, 64'(0));
    ap_rst        = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("mf_no_stale%0d", k), bus.rsp_valid, 64'(0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
